// File: rtl/conway_serial_controller_if.sv
// Host/core signal bundle for the serial Conway controller.
// The slave modport is the controller; the master modport is its environment
// (host request side plus the core's DATA_OUT pin).
interface conway_serial_controller_if #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned GEN_WIDTH = 16
);
  logic                 start;
  logic [GEN_WIDTH-1:0] generations;
  logic [DATA_SIZE-1:0] grid_in;
  logic                 serial_from_core;
  logic [1:0]           mode;
  logic                 serial_to_core;
  logic                 busy;
  logic                 done;
  logic [DATA_SIZE-1:0] grid_out;

  modport master (
    output start, generations, grid_in, serial_from_core,
    input  mode, serial_to_core, busy, done, grid_out
  );

  modport slave (
    input  start, generations, grid_in, serial_from_core,
    output mode, serial_to_core, busy, done, grid_out
  );
endinterface

// File: rtl/conway_serial_controller.sv
// Sequencer for the 8x8 serial Conway core: shifts a grid in (MSB first),
// runs the requested number of generations, shifts the result back out and
// parks the core in stop mode while idle. All outputs come straight from flops.
module conway_serial_controller #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned GEN_WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst,
  conway_serial_controller_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DATA_SIZE);
  localparam logic [CntW-1:0] BitLast = CntW'(DATA_SIZE - 1);
  localparam logic [CntW-1:0] BitOne = CntW'(1);
  localparam logic [GEN_WIDTH-1:0] GenOne = GEN_WIDTH'(1);

  localparam logic [1:0] ModeLoad = 2'b00;
  localparam logic [1:0] ModeRun = 2'b01;
  localparam logic [1:0] ModeOut = 2'b10;
  localparam logic [1:0] ModeStop = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StFinish} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] tx_q, tx_d;
  logic [DATA_SIZE-1:0] rx_q, rx_d;
  logic [DATA_SIZE-1:0] grid_out_q, grid_out_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic [CntW-1:0]      bit_q, bit_d;
  logic [1:0]           mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    grid_out_d = grid_out_q;
    gen_d      = gen_q;
    bit_d      = bit_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          tx_d    = bus.grid_in;
          gen_d   = bus.generations;
          bit_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // tx drains to zero after the last shift, which keeps DATA_IN low afterwards
        tx_d  = tx_q << 1;
        bit_d = bit_q + BitOne;
        if (bit_q == BitLast) begin
          state_d = (gen_q == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        gen_d = gen_q - GenOne;
        if (gen_q == GenOne) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        rx_d  = {rx_q[DATA_SIZE-2:0], bus.serial_from_core};
        bit_d = bit_q + BitOne;
        if (bit_q == BitLast) begin
          // Publish on entry to FINISH so GRID_OUT is already valid while DONE is high
          grid_out_d = rx_d;
          state_d    = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are a function of the state being entered, so they line up with it
    mode_d = ModeStop;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StLoad:   begin mode_d = ModeLoad; busy_d = 1'b1; end
      StRun:    begin mode_d = ModeRun;  busy_d = 1'b1; end
      StDrain:  begin mode_d = ModeOut;  busy_d = 1'b1; end
      StFinish: begin busy_d = 1'b1; done_d = 1'b1; end
      default:  begin mode_d = ModeStop; end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_q       <= '0;
      grid_out_q <= '0;
      gen_q      <= '0;
      bit_q      <= '0;
      mode_q     <= ModeStop;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      grid_out_q <= grid_out_d;
      gen_q      <= gen_d;
      bit_q      <= bit_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mode           = mode_q;
  assign bus.serial_to_core = tx_q[DATA_SIZE-1];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.grid_out       = grid_out_q;

endmodule

// File: tb/tb_conway_serial_controller.sv
// Bench for conway_serial_controller with a behavioural 8x8 serial core attached.
// Driver pushes expected results per accepted START; a monitor pops and checks on DONE.
module tb_conway_serial_controller;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conway_serial_controller_if #(.DATA_SIZE(64), .GEN_WIDTH(16)) bus ();

  conway_serial_controller #(.DATA_SIZE(64), .GEN_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural core: non-wrapping 8x8 Life, cell (r,c) at bit r*8+c
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              if (g[(r + dr) * 8 + (c + dc)]) cnt++;
            end
          end
        end
        n[r * 8 + c] = g[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  logic [63:0] core_q;
  always @(posedge clk) begin
    if (rst) core_q <= '0;
    else begin
      case (bus.mode)
        2'b00:   core_q <= {core_q[62:0], bus.serial_to_core};
        2'b01:   core_q <= life(core_q);
        2'b10:   core_q <= {core_q[62:0], 1'b0};
        default: core_q <= core_q;
      endcase
    end
  end
  assign bus.serial_from_core = core_q[63];

  typedef struct {
    logic [63:0] grid;
    logic [63:0] exp;
    int          g;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks per-operation profile and checks it when DONE appears
  initial begin
    int busy_cnt = 0, load_cnt = 0, run_cnt = 0, drain_cnt = 0;
    logic [63:0] load_vec = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        sb_q.delete();
        busy_cnt = 0; load_cnt = 0; run_cnt = 0; drain_cnt = 0; load_vec = '0;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        case (bus.mode)
          2'b00: begin load_cnt++; load_vec = {load_vec[62:0], bus.serial_to_core}; end
          2'b01: run_cnt++;
          2'b10: drain_cnt++;
          default: ;
        endcase
        if (bus.done === 1'b1) begin
          done_seen++;
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got DONE=1, expected no pending op (cycle %0d)", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("grid_out", bus.grid_out, e.exp);
            chk("latency", 64'(cyc - e.acc + 1), 64'(129 + e.g));
            chk("load_stream", load_vec, e.grid);
            chk("load_cycles", 64'(load_cnt), 64'd64);
            chk("run_cycles", 64'(run_cnt), 64'(e.g));
            chk("drain_cycles", 64'(drain_cnt), 64'd64);
            chk("busy_cycles", 64'(busy_cnt), 64'(129 + e.g));
            chk("mode_at_done", 64'(bus.mode), 64'd3);
          end
          busy_cnt = 0; load_cnt = 0; run_cnt = 0; drain_cnt = 0; load_vec = '0;
        end
      end
    end
  end

  task automatic push(input logic [63:0] grid, input int g, input logic [63:0] exp);
    exp_t e;
    e.grid = grid;
    e.exp  = exp;
    e.g    = g;
    e.acc  = cyc;
    sb_q.push_back(e);
  endtask

  // Present START for one edge from IDLE, then scramble the inputs
  task automatic issue(input logic [63:0] grid, input int g, input logic [63:0] exp);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.grid_in = grid;
    bus.generations = 16'(g);
    @(posedge clk); #2;
    push(grid, g, exp);
    bus.start = 1'b0;
    bus.grid_in = {$urandom, $urandom};
    bus.generations = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_seen;
    n = 0;
    while (done_seen == base && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_seen == base) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no DONE within %0d cycles, expected DONE", budget);
    end
  endtask

  task automatic wait_mode(input logic [1:0] m);
    int n;
    n = 0;
    while (bus.mode !== m && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mode", 64'(bus.mode), 64'(m));
  endtask

  localparam logic [63:0] Ident   = 64'hA5A5_0F0F_F0F0_5A5A;
  localparam logic [63:0] BlinkH  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BlinkV  = 64'h0000_0008_0808_0000;
  localparam logic [63:0] Ends    = 64'h8000_0000_0000_0001;
  localparam logic [63:0] Block   = 64'h0000_0000_0006_0600;
  localparam logic [63:0] GridC   = 64'h0123_4567_89AB_CDEF;

  initial begin
    int base;
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.grid_in = '0;
    bus.generations = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", 64'(bus.mode), 64'd3);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_grid_out", bus.grid_out, 64'd0);
    chk("rst_serial", 64'(bus.serial_to_core), 64'd0);

    issue(Ident, 0, Ident);   wait_done(300);
    issue(BlinkH, 1, BlinkV); wait_done(300);
    issue(BlinkH, 2, BlinkH); wait_done(300);
    issue(Ends, 0, Ends);     wait_done(300);
    issue(Block, 5, Block);   wait_done(300);

    // START during RUN and during FINISH is dropped; START in the next IDLE is taken
    base = done_seen;
    issue(BlinkH, 3, BlinkV);
    wait_mode(2'b01);
    bus.start = 1'b1;
    bus.grid_in = Ident;
    bus.generations = 16'd7;
    @(posedge clk); #2;
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("hs_done_seen", 64'(bus.done), 64'd1);
    bus.start = 1'b1;
    bus.grid_in = GridC;
    bus.generations = 16'd0;
    @(posedge clk);
    @(posedge clk); #2;
    push(GridC, 0, GridC);
    bus.start = 1'b0;
    bus.grid_in = '0;
    wait_done(300);
    repeat (20) @(negedge clk);
    chk("hs_done_count", 64'(done_seen - base), 64'd2);

    // Reset during RUN aborts without DONE and clears GRID_OUT
    issue(64'hFFFF_0000_FFFF_0000, 40, '0);
    wait_mode(2'b01);
    repeat (10) @(negedge clk);
    chk("mid_run_mode", 64'(bus.mode), 64'd1);
    base = done_seen;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_mode", 64'(bus.mode), 64'd3);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_grid_out", bus.grid_out, 64'd0);
    repeat (250) @(negedge clk);
    chk("abort_no_done", 64'(done_seen - base), 64'd0);

    issue(BlinkH, 1, BlinkV); wait_done(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
